// File: rtl/rx78_pkg.sv
// rtl/rx78_pkg.sv - RX-78 VDP I/O map, CPU read FSM states, plane select helper
// Contents:
//   IO_* constants : Z80 I/O addresses decoded by vdp_regfile
//   rd_state_t     : vdp_cpu_port read sequencer states
//   plane_byte()   : picks the 8-bit plane selected by rbank out of {v6..v1}
`timescale 1ns/1ps
package rx78_pkg;

   localparam logic [7:0] IO_RBANK = 8'hF1;
   localparam logic [7:0] IO_WBANK = 8'hF2;
   localparam logic [7:0] IO_P1    = 8'hF5;
   localparam logic [7:0] IO_P2    = 8'hF6;
   localparam logic [7:0] IO_P3    = 8'hF7;
   localparam logic [7:0] IO_P4    = 8'hF8;
   localparam logic [7:0] IO_P5    = 8'hF9;
   localparam logic [7:0] IO_P6    = 8'hFA;
   localparam logic [7:0] IO_CMASK = 8'hFB;
   localparam logic [7:0] IO_BGC   = 8'hFC;
   localparam logic [7:0] IO_MASK  = 8'hFE;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_ISS  = 2'd1,
      ST_RD_CAP  = 2'd2,
      ST_RD_DONE = 2'd3
   } rd_state_t;

   // Banks 1..6 map to v1..v6; 0 and 7 have no plane behind them and read as $FF.
   function automatic logic [7:0] plane_byte(input logic [47:0] rdata, input logic [2:0] bank);
      logic [7:0] b;
      case (bank)
         3'd1:    b = rdata[7:0];
         3'd2:    b = rdata[15:8];
         3'd3:    b = rdata[23:16];
         3'd4:    b = rdata[31:24];
         3'd5:    b = rdata[39:32];
         3'd6:    b = rdata[47:40];
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/vdp_regfile.sv
// rtl/vdp_regfile.sv - VDP I/O register decode and display register outputs
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   io_addr, io_wr, io_din   : Z80 I/O write (level strobe, repeats harmlessly)
//   rbank, wbank             : VRAM read plane select / per-plane write enables
//   p1..p6, cmask, bgc, mask : display registers
`timescale 1ns/1ps
module vdp_regfile
   import rx78_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] io_addr,
   input  logic       io_wr,
   input  logic [7:0] io_din,
   output logic [2:0] rbank,
   output logic [5:0] wbank,
   output logic [7:0] p1,
   output logic [7:0] p2,
   output logic [7:0] p3,
   output logic [7:0] p4,
   output logic [7:0] p5,
   output logic [7:0] p6,
   output logic [7:0] cmask,
   output logic [7:0] bgc,
   output logic [7:0] mask
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbank <= '0;
         wbank <= '0;
         p1    <= '0;
         p2    <= '0;
         p3    <= '0;
         p4    <= '0;
         p5    <= '0;
         p6    <= '0;
         cmask <= '0;
         bgc   <= '0;
         mask  <= '0;
      end else if (io_wr) begin
         case (io_addr)
            IO_RBANK: rbank <= io_din[2:0];
            IO_WBANK: wbank <= io_din[5:0];
            IO_P1:    p1    <= io_din;
            IO_P2:    p2    <= io_din;
            IO_P3:    p3    <= io_din;
            IO_P4:    p4    <= io_din;
            IO_P5:    p5    <= io_din;
            IO_P6:    p6    <= io_din;
            IO_CMASK: cmask <= io_din;
            IO_BGC:   bgc   <= io_din;
            IO_MASK:  mask  <= io_din;
            default:  ;
         endcase
      end
   end

endmodule

// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - Z80 access port into VDP registers and the six VRAM planes
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   vclk                       : display owns the VRAM port while high
//   io_addr, io_wr, io_din     : I/O register writes (see vdp_regfile)
//   cpu_addr, mem_wr, mem_rd,
//   cpu_din, cpu_dout, cpu_wait: memory access in the $E000 window, stall output
//   vram_sel, vram_addr,
//   vram_we, vram_wdata,
//   vram_rdata                 : VRAM port towards the planes ({v6..v1} on read)
//   p1..p6, cmask, bgc, mask   : display registers
`timescale 1ns/1ps
module vdp_cpu_port
   import rx78_pkg::*;
#(
   parameter logic [2:0] WIN_BASE = 3'b111
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vclk,
   input  logic [7:0]  io_addr,
   input  logic        io_wr,
   input  logic [7:0]  io_din,
   input  logic [15:0] cpu_addr,
   input  logic        mem_wr,
   input  logic        mem_rd,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_wait,
   output logic        vram_sel,
   output logic [12:0] vram_addr,
   output logic [5:0]  vram_we,
   output logic [7:0]  vram_wdata,
   input  logic [47:0] vram_rdata,
   output logic [7:0]  p1,
   output logic [7:0]  p2,
   output logic [7:0]  p3,
   output logic [7:0]  p4,
   output logic [7:0]  p5,
   output logic [7:0]  p6,
   output logic [7:0]  cmask,
   output logic [7:0]  bgc,
   output logic [7:0]  mask
);

   logic [2:0]  rbank;
   logic [5:0]  wbank;
   rd_state_t   state;
   logic        acc;
   logic        wb_full;
   logic [12:0] wb_addr;
   logic [7:0]  wb_data;
   logic        win;
   logic        wr_accept;
   logic        rd_accept;
   logic        drain;
   logic        rd_issue;

   vdp_regfile u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .io_addr (io_addr),
      .io_wr   (io_wr),
      .io_din  (io_din),
      .rbank   (rbank),
      .wbank   (wbank),
      .p1      (p1),
      .p2      (p2),
      .p3      (p3),
      .p4      (p4),
      .p5      (p5),
      .p6      (p6),
      .cmask   (cmask),
      .bgc     (bgc),
      .mask    (mask)
   );

   // acc blocks re-acceptance of a strobe the CPU is still holding.
   // A read only issues once the buffer is empty, so drain and read issue
   // can never claim the port in the same cycle.
   always_comb begin
      win       = (cpu_addr[15:13] == WIN_BASE);
      wr_accept = mem_wr & win & ~acc & ~wb_full;
      rd_accept = mem_rd & win & ~acc & (state == ST_IDLE);
      drain     = wb_full & ~vclk;
      rd_issue  = (state == ST_RD_ISS) & ~vclk & ~wb_full;
      cpu_wait  = (mem_rd & win & (state != ST_RD_DONE))
                | (mem_wr & win & ~acc & wb_full);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         acc        <= 1'b0;
         wb_full    <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         cpu_dout   <= 8'hFF;
         vram_sel   <= 1'b0;
         vram_we    <= '0;
         vram_addr  <= '0;
         vram_wdata <= '0;
      end else begin
         // Port strobes are single-cycle pulses unless re-asserted below.
         vram_sel <= 1'b0;
         vram_we  <= '0;

         if (!mem_wr && !mem_rd)
            acc <= 1'b0;
         else if (wr_accept || rd_accept)
            acc <= 1'b1;

         if (wr_accept) begin
            wb_full <= 1'b1;
            wb_addr <= cpu_addr[12:0];
            wb_data <= cpu_din;
         end else if (drain) begin
            wb_full    <= 1'b0;
            vram_sel   <= 1'b1;
            vram_we    <= wbank;
            vram_addr  <= wb_addr;
            vram_wdata <= wb_data;
         end

         case (state)
            ST_IDLE: begin
               if (rd_accept)
                  state <= ST_RD_ISS;
            end
            ST_RD_ISS: begin
               if (rd_issue) begin
                  vram_sel  <= 1'b1;
                  vram_addr <= cpu_addr[12:0];
                  state     <= ST_RD_CAP;
               end
            end
            ST_RD_CAP: begin
               cpu_dout <= plane_byte(vram_rdata, rbank);
               state    <= ST_RD_DONE;
            end
            ST_RD_DONE: begin
               if (!mem_rd)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb/tb_vdp_cpu_port.sv - directed self-checking bench for vdp_cpu_port
`timescale 1ns/1ps
module tb_vdp_cpu_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vclk;
   logic [7:0]  io_addr;
   logic        io_wr;
   logic [7:0]  io_din;
   logic [15:0] cpu_addr;
   logic        mem_wr;
   logic        mem_rd;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        cpu_wait;
   logic        vram_sel;
   logic [12:0] vram_addr;
   logic [5:0]  vram_we;
   logic [7:0]  vram_wdata;
   logic [47:0] vram_rdata;
   logic [7:0]  p1, p2, p3, p4, p5, p6, cmask, bgc, mask;

   int n_tests = 0;
   int n_fail  = 0;
   int sel_vclk_cnt = 0;

   // VRAM plane model: per-plane byte writes, asynchronous read of the presented address.
   logic [47:0] vmem [0:8191];
   logic        pl_en = 1'b0;
   logic [12:0] pl_addr = '0;
   logic [47:0] pl_data = '0;

   always #5 clk = ~clk;

   vdp_cpu_port dut (
      .clk(clk), .rst_n(rst_n), .vclk(vclk),
      .io_addr(io_addr), .io_wr(io_wr), .io_din(io_din),
      .cpu_addr(cpu_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
      .vram_sel(vram_sel), .vram_addr(vram_addr), .vram_we(vram_we),
      .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
      .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6),
      .cmask(cmask), .bgc(bgc), .mask(mask)
   );

   assign vram_rdata = vmem[vram_addr];

   always @(posedge clk) begin
      if (pl_en)
         vmem[pl_addr] <= pl_data;
      else if (vram_sel)
         for (int p = 0; p < 6; p++)
            if (vram_we[p]) vmem[vram_addr][8*p +: 8] <= vram_wdata;
   end

   always @(posedge clk)
      if (rst_n && vram_sel && vclk) sel_vclk_cnt++;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // All tasks enter and leave just after a falling clock edge.
   task automatic preload(input logic [12:0] a, input logic [47:0] d);
      pl_addr = a; pl_data = d; pl_en = 1'b1;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic io_write(input logic [7:0] a, input logic [7:0] d);
      io_addr = a; io_din = d; io_wr = 1'b1;
      @(negedge clk);
      io_wr = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int waits);
      cpu_addr = a; cpu_din = d; mem_wr = 1'b1;
      #1;
      waits = 0;
      while (cpu_wait && waits < 20) begin
         @(negedge clk); #1; waits++;
      end
      @(negedge clk);
      mem_wr = 1'b0;
      @(negedge clk);
   endtask

   // vhold: number of cycles, counted from the strobe, during which vclk is high.
   task automatic cpu_read(input logic [15:0] a, input int vhold, output logic [7:0] d, output int waits);
      cpu_addr = a; mem_rd = 1'b1; vclk = (vhold > 0);
      #1;
      waits = 0;
      while (cpu_wait && waits < 20) begin
         @(negedge clk); waits++; vclk = (waits < vhold); #1;
      end
      d = cpu_dout;
      mem_rd = 1'b0; vclk = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      #1;
      n_tests++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL reset_wait: got %b want 0", cpu_wait); end
      n_tests++; if (vram_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", vram_sel); end
      n_tests++; if (vram_we !== 6'h00) begin n_fail++; $display("FAIL reset_we: got %h want 00", vram_we); end
      n_tests++; if (vram_addr !== 13'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", vram_addr); end
      n_tests++; if (vram_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", vram_wdata); end
      n_tests++; if (cpu_dout !== 8'hFF) begin n_fail++; $display("FAIL reset_dout: got %h want FF", cpu_dout); end
      n_tests++; if ({p1,p2,p3,p4,p5,p6,cmask,bgc,mask} !== 72'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", {p1,p2,p3,p4,p5,p6,cmask,bgc,mask}); end
   endtask

   task automatic test_io_regs;
      io_write(8'hF5, 8'h44);
      n_tests++; if (p1 !== 8'h44) begin n_fail++; $display("FAIL io_p1: got %h want 44", p1); end
      io_write(8'hFB, 8'h32);
      io_write(8'hFE, 8'h32);
      io_write(8'hFC, 8'h32);
      n_tests++; if (cmask !== 8'h32) begin n_fail++; $display("FAIL io_cmask: got %h want 32", cmask); end
      n_tests++; if (mask !== 8'h32) begin n_fail++; $display("FAIL io_mask: got %h want 32", mask); end
      n_tests++; if (bgc !== 8'h32) begin n_fail++; $display("FAIL io_bgc: got %h want 32", bgc); end
      io_write(8'hF6, 8'h11); io_write(8'hF7, 8'h22); io_write(8'hF8, 8'h33);
      io_write(8'hF9, 8'h55); io_write(8'hFA, 8'h66);
      n_tests++; if ({p2,p3,p4,p5,p6} !== 40'h11_22_33_55_66) begin n_fail++; $display("FAIL io_p2_p6: got %h want 1122335566", {p2,p3,p4,p5,p6}); end
      io_write(8'hF3, 8'h77);
      io_write(8'hFD, 8'h77);
      n_tests++; if ({p1,p2,p3,p4,p5,p6,cmask,bgc,mask} !== 72'h44_11_22_33_55_66_32_32_32) begin n_fail++; $display("FAIL io_unmapped: got %h want 441122335566323232", {p1,p2,p3,p4,p5,p6,cmask,bgc,mask}); end
   endtask

   task automatic test_write_single;
      int w, pulses;
      logic [5:0] we_s; logic [12:0] a_s; logic [7:0] d_s;
      vclk = 1'b0;
      io_write(8'hF2, 8'h05);
      cpu_write(16'hEEC0, 8'hA5, w);
      n_tests++; if (w !== 0) begin n_fail++; $display("FAIL wr_wait: got %0d wait cycles want 0", w); end
      pulses = 0; we_s = '0; a_s = '0; d_s = '0;
      for (int i = 0; i < 4; i++) begin
         if (vram_we != 6'h00) begin pulses++; we_s = vram_we; a_s = vram_addr; d_s = vram_wdata; end
         @(negedge clk);
      end
      n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL wr_pulses: got %0d want 1", pulses); end
      n_tests++; if ({we_s, a_s, d_s} !== {6'b000101, 13'h0EC0, 8'hA5}) begin n_fail++; $display("FAIL wr_drain: got we=%b addr=%h data=%h want we=000101 addr=0EC0 data=A5", we_s, a_s, d_s); end
   endtask

   task automatic test_back_to_back;
      vclk = 1'b1; cpu_addr = 16'hE010; cpu_din = 8'h11; mem_wr = 1'b1;
      #1;
      n_tests++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL b2b_first_wait: got %b want 0", cpu_wait); end
      @(negedge clk); mem_wr = 1'b0;
      @(negedge clk); cpu_addr = 16'hE011; cpu_din = 8'h22; mem_wr = 1'b1; #1;
      n_tests++; if (cpu_wait !== 1'b1) begin n_fail++; $display("FAIL b2b_wait_c2: got %b want 1", cpu_wait); end
      @(negedge clk); vclk = 1'b0; #1;
      n_tests++; if (cpu_wait !== 1'b1) begin n_fail++; $display("FAIL b2b_wait_c3: got %b want 1", cpu_wait); end
      n_tests++; if (vram_sel !== 1'b0) begin n_fail++; $display("FAIL b2b_no_early_drain: got %b want 0", vram_sel); end
      @(negedge clk); #1;
      n_tests++; if ({vram_we, vram_addr, vram_wdata} !== {6'b000101, 13'h0010, 8'h11}) begin n_fail++; $display("FAIL b2b_drain1: got we=%b addr=%h data=%h want 000101/0010/11", vram_we, vram_addr, vram_wdata); end
      n_tests++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL b2b_wait_release: got %b want 0", cpu_wait); end
      @(negedge clk); mem_wr = 1'b0;
      @(negedge clk); #1;
      n_tests++; if ({vram_we, vram_addr, vram_wdata} !== {6'b000101, 13'h0011, 8'h22}) begin n_fail++; $display("FAIL b2b_drain2: got we=%b addr=%h data=%h want 000101/0011/22", vram_we, vram_addr, vram_wdata); end
      @(negedge clk);
   endtask

   task automatic test_read;
      logic [7:0] d; int w;
      preload(13'h1000, 48'h66_55_44_5A_22_11);
      io_write(8'hF1, 8'h03);
      cpu_read(16'hF000, 0, d, w);
      n_tests++; if (w !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d wait cycles want 3", w); end
      n_tests++; if (d !== 8'h5A) begin n_fail++; $display("FAIL rd_plane3: got %h want 5A", d); end
      io_write(8'hF1, 8'h06);
      cpu_read(16'hF000, 3, d, w);
      n_tests++; if (w !== 5) begin n_fail++; $display("FAIL rd_vclk_latency: got %0d wait cycles want 5", w); end
      n_tests++; if (d !== 8'h66) begin n_fail++; $display("FAIL rd_plane6: got %h want 66", d); end
      io_write(8'hF1, 8'h00);
      cpu_read(16'hF000, 0, d, w);
      n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL rd_bank0: got %h want FF", d); end
      io_write(8'hF1, 8'h07);
      cpu_read(16'hF000, 0, d, w);
      n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL rd_bank7: got %h want FF", d); end
   endtask

   task automatic test_write_then_read;
      logic [7:0] d; int w;
      preload(13'h0123, 48'h0);
      io_write(8'hF2, 8'h04);
      io_write(8'hF1, 8'h03);
      vclk = 1'b1;
      cpu_write(16'hE123, 8'hC3, w);
      cpu_read(16'hE123, 3, d, w);
      n_tests++; if (d !== 8'hC3) begin n_fail++; $display("FAIL wr_rd_order: got %h want C3", d); end
      n_tests++; if (w !== 6) begin n_fail++; $display("FAIL wr_rd_latency: got %0d wait cycles want 6", w); end
   endtask

   task automatic test_window;
      int sels;
      vclk = 1'b0; sels = 0;
      cpu_addr = 16'hDFFF; cpu_din = 8'h99; mem_wr = 1'b1; #1;
      n_tests++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL win_wr_wait: got %b want 0", cpu_wait); end
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (vram_sel) sels++; end
      mem_wr = 1'b0;
      @(negedge clk); if (vram_sel) sels++;
      cpu_addr = 16'h8000; mem_rd = 1'b1; #1;
      n_tests++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL win_rd_wait: got %b want 0", cpu_wait); end
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (vram_sel) sels++; end
      mem_rd = 1'b0;
      @(negedge clk);
      n_tests++; if (sels !== 0) begin n_fail++; $display("FAIL win_port_use: got %0d vram_sel cycles want 0", sels); end
      n_tests++; if (cpu_dout !== 8'hC3) begin n_fail++; $display("FAIL win_dout_kept: got %h want C3", cpu_dout); end
   endtask

   task automatic test_reset_mid;
      int sels;
      io_write(8'hF2, 8'h05);
      vclk = 1'b1; cpu_addr = 16'hE050; cpu_din = 8'h77; mem_wr = 1'b1;
      @(negedge clk);
      mem_wr = 1'b0; rst_n = 1'b0; vclk = 1'b0; #1;
      n_tests++; if ({cpu_wait, vram_sel, vram_we, vram_addr, vram_wdata} !== 29'h0) begin n_fail++; $display("FAIL rstmid_port: got wait=%b sel=%b we=%h addr=%h data=%h want all 0", cpu_wait, vram_sel, vram_we, vram_addr, vram_wdata); end
      n_tests++; if (cpu_dout !== 8'hFF) begin n_fail++; $display("FAIL rstmid_dout: got %h want FF", cpu_dout); end
      n_tests++; if ({p1, cmask, mask} !== 24'h0) begin n_fail++; $display("FAIL rstmid_regs: got %h want 0", {p1, cmask, mask}); end
      sels = 0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (vram_sel || vram_we != 6'h00) sels++; end
      n_tests++; if (sels !== 0) begin n_fail++; $display("FAIL rstmid_discard: got %0d drain cycles want 0", sels); end
   endtask

   initial begin
      rst_n = 1'b0; vclk = 1'b0; io_addr = '0; io_wr = 1'b0; io_din = '0;
      cpu_addr = '0; mem_wr = 1'b0; mem_rd = 1'b0; cpu_din = '0;
      @(negedge clk); @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      @(negedge clk);
      test_io_regs;
      test_write_single;
      test_back_to_back;
      test_read;
      test_write_then_read;
      test_window;
      test_reset_mid;
      n_tests++; if (sel_vclk_cnt !== 0) begin n_fail++; $display("FAIL sel_during_vclk: got %0d cycles want 0", sel_vclk_cnt); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vdp_cpu_port.md
# vdp_cpu_port

CPU-side access port for the RX-78 video subsystem, driving the opposite direction of the display fetch path. It decodes Z80 I/O writes into the VDP register file: palettes p1–p6, cmask, bgc, mask, and the VRAM read/write bank selects. It also services CPU memory reads and writes into the six 1-bit VRAM planes through a one-entry posted write buffer. CPU accesses are arbitrated against display fetch slots, which are marked by `vclk`, and the CPU is stalled with `cpu_wait` when a slot is unavailable.

## Interface
Parameters:
- `WIN_BASE`, 3'b111: `cpu_addr[15:13]` value selecting the VRAM window $E000–$FFFF.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `vclk`  in  1  display fetch strobe. When high, the VRAM port belongs to the display during that `clk` cycle.
- `io_addr`  in  8  Z80 I/O address, low byte.
- `io_wr`  in  1  I/O write strobe, level, held for the whole access.
- `io_din`  in  8  I/O write data.
- `cpu_addr`  in  16  Z80 memory address.
- `mem_wr`, `mem_rd`  in  1  memory strobes, level, held while `cpu_wait`=1.
- `cpu_din`  in  8  memory write data.
- `cpu_dout`  out  8  memory read data.
- `cpu_wait`  out  1  stall request to the CPU.
- `vram_sel`  out  1  when 1, the VRAM address mux takes `vram_addr` from this block.
- `vram_addr`  out  13  VRAM byte address, equal to `cpu_addr[12:0]`.
- `vram_we`  out  6  per-plane write enables.
- `vram_wdata`  out  8  write data.
- `vram_rdata`  in  48  plane read data {v6..v1}, valid one cycle after the address is presented.
- `p1`..`p6`, `cmask`, `bgc`, `mask`  out  8 each  display registers.

## Operation
- **I/O register decode.**
  - `io_wr` high and `io_addr` equal to $F1 / $F2 / $F5–$FA / $FB / $FC / $FE loads `rbank[2:0]` / `wbank[5:0]` / p1–p6 / cmask / bgc / mask respectively.
  - The write repeats each cycle while `io_wr` is held. This is idempotent.
  - Other I/O addresses are ignored.
  - All registers reset to 0.
- **Memory window.** An access is in the window when `cpu_addr[15:13]`==`WIN_BASE`. Accesses outside the window are ignored and `cpu_wait`=0.
- **Strobe acceptance.**
  - Each memory strobe is accepted once. An `acc` flag is set on acceptance and cleared when both `mem_wr` and `mem_rd` are low.
- **Writes.**
  - A write is accepted when the buffer is empty. The block latches the address and data, sets `wb_full`, and drops `cpu_wait`.
  - If `wb_full`=1, `cpu_wait`=1 until the buffer drains, and the write is then accepted.
- **Write drain.** `wb_full` drains in the first cycle with `vclk`=0. In that cycle `vram_sel`=1, `vram_we`=`wbank`, and `vram_wdata` is the latched data. `wbank`=0 drains with no effect.
- **Reads.**
  - A read waits for `wb_full`=0, which preserves ordering.
  - It then presents the address in the first `vclk`=0 cycle and captures the next cycle.
  - Captured data is plane `rbank` (1..6 selects v1..v6). `rbank` equal to 0 or 7 returns $FF.
- **Register state machine.**
  - IDLE: on an accepted read, go to RD_ISS.
  - RD_ISS: when `vclk`=0 and `wb_full`=0, drive `vram_sel`=1 and go to RD_CAP.
  - RD_CAP: load `cpu_dout` and go to RD_DONE.
  - RD_DONE: stay until `mem_rd`=0, then go to IDLE.
- **Write drain and the FSM.** The write drain is independent of the FSM state but shares the port. In any cycle, priority is display (`vclk`) > write drain > read issue.
- **`cpu_wait`** (combinational) =
  - (`mem_rd` & window & state≠RD_DONE), or
  - (`mem_wr` & window & !`acc` & `wb_full`).
- **Reset mid-access.** Reset clears the FSM to IDLE, `wb_full`=0, `acc`=0, and `cpu_dout`=$FF. A pending write is discarded.

## Timing
- Reset values:
  - `cpu_wait`=0, `vram_sel`=0, `vram_we`=0, `vram_addr`=0, `vram_wdata`=0, `cpu_dout`=$FF.
  - All registers 0.
- Register write: the output updates on the `clk` edge that samples `io_wr`, so the new value is visible the next cycle.
- Write latency: accept at edge N, drain at the first edge ≥N+1 with `vclk`=0.
- Read latency with no contention: accept at N, RD_ISS at N+1, capture at N+2, `cpu_wait` low from N+3.
  - Each `vclk`=1 cycle in RD_ISS adds one cycle.
- `vram_sel` and `vram_we` are registered and are never asserted in a cycle where `vclk`=1.

## Structure
- Shared package `rx78_pkg`: I/O address constants (`IO_RBANK`=$F1, `IO_WBANK`=$F2, `IO_P1`..`IO_P6`=$F5..$FA, `IO_CMASK`=$FB, `IO_BGC`=$FC, `IO_MASK`=$FE) and the read-FSM state enum.
- One natural sub-module, `vdp_regfile`: the I/O decode and register outputs.

## Test plan
- I/O write $44 to $F5, then $32 to $FB, $FE, $FC → `p1`=$44, `cmask`=$32; `mask`/`bgc` load; $F3 write leaves all registers unchanged.
- `wbank`=6'b000101, `mem_wr` $EEC0←$A5 with `vclk`=0 → one cycle of `vram_we`=6'b000101, `vram_addr`=$0EC0, `vram_wdata`=$A5; `cpu_wait` never 1.
- Two back-to-back writes with `vclk` held 1 for 3 cycles → second write sees `cpu_wait`=1 until the first drains; the drain happens in the cycle after `vclk` falls.
- `rbank`=3, `vram_rdata` plane 3=$5A, `mem_rd` $F000 → `cpu_wait` high 3 cycles, `cpu_dout`=$5A; `rbank`=0 → $FF.
- Write immediately followed by a read of the same address → read returns the written byte.
- Assert `rst_n`=0 with `wb_full`=1 → no `vram_we` pulse; all outputs at reset values.
